// File: rtl/didactic_uart_pkg.sv
// Shared constants and types for the didactic UART transmitter.
// Holds the APB register offsets, the reset baud divider and the TX FSM state type.
package didactic_uart_pkg;

  localparam logic [3:0] TXDATA_OFFS   = 4'h0;
  localparam logic [3:0] STATUS_OFFS   = 4'h4;
  localparam logic [3:0] BAUD_DIV_OFFS = 4'h8;

  localparam int unsigned DEFAULT_DIV = 68;
  localparam int unsigned DIV_W       = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/didactic_uart_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports: clk, rst (async, active-high), push/push_data, pop/pop_data,
//        full, empty, level (log2(DEPTH)+1 bits).
// A push is judged against the pre-pop level, so a push while full is dropped
// even if a pop happens in the same cycle.
module didactic_uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_q];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/didactic_uart_tx.sv
// APB-programmable UART transmitter: TXDATA pushes bytes into a FIFO, the TX
// FSM serialises them LSB first as 8N1 frames (8E1 with the parity option).
// Ports: clk_in, reset (async, active-high), APB slave (psel, penable, pwrite,
//        paddr, pwdata, prdata, pready, pslverr), uart_tx, tx_empty_irq.
// Option macro: DIDACTIC_UART_TX_PARITY_EN inserts an even-parity bit.
module didactic_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = didactic_uart_pkg::DEFAULT_DIV
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        uart_tx,
  output logic        tx_empty_irq
);

  import didactic_uart_pkg::*;

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

`ifdef DIDACTIC_UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic             access;
  logic             bad_addr;
  logic             wr_txdata;
  logic             wr_baud;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [LVL_W-1:0] fifo_level;
  logic [DIV_W-1:0] baud_div_q;
  logic             unused_bits;

  uart_tx_state_t   state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;

  // APB decode; offsets 0xC and above are unmapped
  assign access    = psel & penable;
  assign bad_addr  = (paddr[3:2] == 2'b11);
  assign wr_txdata = access & pwrite & (paddr[3:2] == TXDATA_OFFS[3:2]);
  assign wr_baud   = access & pwrite & (paddr[3:2] == BAUD_DIV_OFFS[3:2]);
  assign pready    = 1'b1;
  assign pslverr   = access & (bad_addr | (wr_txdata & fifo_full));
  assign unused_bits = ^{paddr[1:0], pwdata[31:DIV_W]};

  // Read mux, zero outside the access phase
  always_comb begin
    prdata = '0;
    if (access && !pwrite) begin
      case (paddr[3:2])
        STATUS_OFFS[3:2]: begin
          prdata[0]    = fifo_full;
          prdata[1]    = fifo_empty;
          prdata[2]    = (state_q != IDLE);
          prdata[3]    = PARITY_EN;
          prdata[13:7] = 7'(fifo_level);
        end
        BAUD_DIV_OFFS[3:2]: prdata[DIV_W-1:0] = baud_div_q;
        default:            prdata = '0;
      endcase
    end
  end

  // Programmable divider; only sampled at frame start
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      baud_div_q <= DIV_W'(DEFAULT_DIV);
    end else if (wr_baud) begin
      baud_div_q <= pwdata[DIV_W-1:0];
    end
  end

  didactic_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (reset),
    .push      (wr_txdata),
    .push_data (pwdata[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // TX FSM state register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // TX FSM next state; tx_d is the line level for the coming cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    idx_d    = idx_q;
    data_d   = data_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_rdata;
          div_d    = baud_div_q;
          cnt_d    = baud_div_q;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          idx_d   = '0;
          tx_d    = data_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q;
          if (idx_q == 3'd7) begin
`ifdef DIDACTIC_UART_TX_PARITY_EN
            tx_d    = ^data_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next frame when data is waiting
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            data_d   = fifo_rdata;
            div_d    = baud_div_q;
            cnt_d    = baud_div_q;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign uart_tx      = tx_q;
  assign tx_empty_irq = fifo_empty & (state_q == IDLE);

endmodule

// File: tb/tb_didactic_uart_tx.sv
// Self-checking bench for didactic_uart_tx: APB driver tasks, a scoreboard of
// expected frames and a cycle-exact line monitor that decodes uart_tx.
`timescale 1ns/1ps
module tb_didactic_uart_tx;

  localparam logic [3:0] TX_A   = 4'h0;
  localparam logic [3:0] ST_A   = 4'h4;
  localparam logic [3:0] BAUD_A = 4'h8;
  localparam logic [3:0] BAD_A  = 4'hC;
  localparam int         DEPTH  = 8;
`ifdef DIDACTIC_UART_TX_PARITY_EN
  localparam int          NBITS      = 11;
  localparam logic [31:0] PAR_STATUS = 32'h8;
`else
  localparam int          NBITS      = 10;
  localparam logic [31:0] PAR_STATUS = 32'h0;
`endif

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] div;
  } sb_entry_t;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        psel   = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  paddr  = 4'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        uart_tx;
  logic        tx_empty_irq;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [15:0] cur_div = 16'd68;
  bit          mon_busy = 1'b0;
  sb_entry_t   exp_q[$];
  int          starts[$];

  didactic_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(68)) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .uart_tx      (uart_tx),
    .tx_empty_irq (tx_empty_irq)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  // Line monitor: every cycle of every bit must carry the expected level
  initial begin : rx_monitor
    sb_entry_t   e;
    logic [10:0] line;
    int          b;
    int          c;
    int          bad_bit;
    logic        bad_val;
    bit          aborted;
    forever begin
      @(negedge clk_in);
      if (!reset && uart_tx === 1'b0) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame: start bit seen at cycle %0d, required no frame", cyc);
          c = 0;
          while (uart_tx !== 1'b1 && !reset && c < 20000) begin
            @(negedge clk_in);
            c++;
          end
        end else begin
          e = exp_q.pop_front();
          mon_busy = 1'b1;
`ifdef DIDACTIC_UART_TX_PARITY_EN
          line = {1'b1, ^e.data, e.data, 1'b0};
`else
          line = {2'b11, e.data, 1'b0};
`endif
          b = 0;
          c = 0;
          bad_bit = -1;
          bad_val = 1'b0;
          aborted = 1'b0;
          while (b < NBITS && !aborted) begin
            if (reset) begin
              aborted = 1'b1;
            end else begin
              if (uart_tx !== line[b] && bad_bit < 0) begin
                bad_bit = b;
                bad_val = uart_tx;
              end
              c++;
              if (c > int'(e.div)) begin
                c = 0;
                b++;
              end
              if (b < NBITS) @(negedge clk_in);
            end
          end
          if (!aborted) begin
            checks++;
            if (bad_bit >= 0)
              $display("FAIL frame_0x%02h: bit %0d read %b, required %b (div %0d)",
                       e.data, bad_bit, bad_val, line[bad_bit], e.div);
            else
              passed++;
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk_in);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk_in);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk_in);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk_in);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk_in);
    penable = 1'b1;
    #1;
    data = prdata;
    err  = pslverr;
    @(posedge clk_in);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic sb_push(input logic [7:0] data);
    sb_entry_t e;
    e.data = data;
    e.div  = cur_div;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    while ((mon_busy || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk_in);
      n++;
    end
    ok = !(mon_busy || exp_q.size() != 0);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        err;
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (uart_tx !== 1'b1) $display("FAIL rst_uart_tx: got %b, required 1", uart_tx); else passed++;
    checks++; if (tx_empty_irq !== 1'b1) $display("FAIL rst_irq: got %b, required 1", tx_empty_irq); else passed++;
    checks++; if (pready !== 1'b1) $display("FAIL rst_pready: got %b, required 1", pready); else passed++;
    checks++; if (pslverr !== 1'b0) $display("FAIL rst_pslverr: got %b, required 0", pslverr); else passed++;
    checks++; if (prdata !== 32'h0) $display("FAIL rst_prdata: got 0x%08h, required 0", prdata); else passed++;
    reset = 1'b0;
    cur_div = 16'd68;
    apb_read(ST_A, rd, err);
    checks++; if (rd !== (32'h2 | PAR_STATUS)) $display("FAIL rst_status: got 0x%08h, required 0x%08h", rd, 32'h2 | PAR_STATUS); else passed++;
    apb_read(BAUD_A, rd, err);
    checks++; if (rd !== 32'd68) $display("FAIL rst_baud: got %0d, required 68", rd); else passed++;
  endtask

  task automatic test_single_frame();
    logic err;
    int   wr_cyc;
    bit   ok;
    int   st;
    starts.delete();
    apb_write(TX_A, 32'h55, err);
    wr_cyc = cyc;
    sb_push(8'h55);
    checks++; if (err !== 1'b0) $display("FAIL single_err: got %b, required 0", err); else passed++;
    checks++; if (uart_tx !== 1'b1) $display("FAIL single_tx_after_write: got %b, required 1", uart_tx); else passed++;
    checks++; if (tx_empty_irq !== 1'b0) $display("FAIL single_irq_fall: got %b, required 0", tx_empty_irq); else passed++;
    @(posedge clk_in); #1;
    checks++; if (uart_tx !== 1'b0) $display("FAIL single_start_latency: got %b, required 0", uart_tx); else passed++;
    repeat (NBITS * 69 - 1) @(posedge clk_in);
    #1;
    checks++; if (tx_empty_irq !== 1'b0) $display("FAIL single_irq_last_stop: got %b, required 0", tx_empty_irq); else passed++;
    @(posedge clk_in); #1;
    checks++; if (tx_empty_irq !== 1'b1) $display("FAIL single_irq_rise: got %b, required 1", tx_empty_irq); else passed++;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL single_drain: monitor busy %b, %0d left, required idle", mon_busy, exp_q.size()); else passed++;
    st = (starts.size() == 1) ? starts[0] : -1;
    checks++; if (st !== wr_cyc + 1) $display("FAIL single_start_cycle: got %0d, required %0d", st, wr_cyc + 1); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        err;
    bit          ok;
    int          gap;
    apb_write(BAUD_A, 32'd3, err);
    cur_div = 16'd3;
    apb_read(BAUD_A, rd, err);
    checks++; if (rd !== 32'd3) $display("FAIL b2b_baud_rd: got %0d, required 3", rd); else passed++;
    starts.delete();
    apb_write(TX_A, 32'hA5, err);
    sb_push(8'hA5);
    checks++; if (err !== 1'b0) $display("FAIL b2b_err0: got %b, required 0", err); else passed++;
    apb_write(TX_A, 32'h3C, err);
    sb_push(8'h3C);
    checks++; if (err !== 1'b0) $display("FAIL b2b_err1: got %b, required 0", err); else passed++;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL b2b_drain: %0d frames left, required 0", exp_q.size()); else passed++;
    gap = (starts.size() == 2) ? starts[1] - starts[0] : -1;
    checks++; if (gap !== NBITS * 4) $display("FAIL b2b_gap: got %0d, required %0d", gap, NBITS * 4); else passed++;
    @(posedge clk_in); #1;
    checks++; if (tx_empty_irq !== 1'b1) $display("FAIL b2b_irq_end: got %b, required 1", tx_empty_irq); else passed++;
  endtask

  task automatic test_bad_offset();
    logic [31:0] rd;
    logic        err;
    apb_read(BAD_A, rd, err);
    checks++; if (rd !== 32'h0) $display("FAIL bad_rd_data: got 0x%08h, required 0", rd); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL bad_rd_slverr: got %b, required 1", err); else passed++;
    apb_write(BAD_A, 32'h0000_0007, err);
    checks++; if (err !== 1'b1) $display("FAIL bad_wr_slverr: got %b, required 1", err); else passed++;
    apb_read(TX_A, rd, err);
    checks++; if (rd !== 32'h0 || err !== 1'b0) $display("FAIL txdata_rd: got 0x%08h/%b, required 0/0", rd, err); else passed++;
    apb_write(ST_A, 32'hFFFF_FFFF, err);
    apb_read(ST_A, rd, err);
    checks++; if (rd !== (32'h2 | PAR_STATUS)) $display("FAIL status_ro: got 0x%08h, required 0x%08h", rd, 32'h2 | PAR_STATUS); else passed++;
    apb_read(BAUD_A, rd, err);
    checks++; if (rd !== 32'(cur_div)) $display("FAIL baud_kept: got %0d, required %0d", rd, cur_div); else passed++;
  endtask

  task automatic test_baud_change();
    logic err;
    bit   ok;
    int   gap;
    int   old_len;
    starts.delete();
    old_len = NBITS * (int'(cur_div) + 1);
    apb_write(TX_A, 32'h12, err);
    sb_push(8'h12);
    // New divider lands mid-frame; the queued byte must use it
    apb_write(BAUD_A, 32'd5, err);
    cur_div = 16'd5;
    apb_write(TX_A, 32'h34, err);
    sb_push(8'h34);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL baud_chg_drain: %0d frames left, required 0", exp_q.size()); else passed++;
    gap = (starts.size() == 2) ? starts[1] - starts[0] : -1;
    checks++; if (gap !== old_len) $display("FAIL baud_chg_gap: got %0d, required %0d", gap, old_len); else passed++;
  endtask

`ifdef DIDACTIC_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [31:0] rd;
    logic        err;
    bit          ok;
    apb_write(TX_A, 32'h07, err);
    sb_push(8'h07);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL parity_drain: %0d frames left, required 0", exp_q.size()); else passed++;
    apb_read(ST_A, rd, err);
    checks++; if (rd[3] !== 1'b1) $display("FAIL parity_status: got %b, required 1", rd[3]); else passed++;
  endtask
`endif

  task automatic test_overflow_reset();
    logic [31:0] rd;
    logic        err;
    logic        exp_err;
    logic [7:0]  d;
    int          first_cyc;
    logic [31:0] exp_st;
    apb_write(BAUD_A, 32'd1000, err);
    cur_div = 16'd1000;
    starts.delete();
    first_cyc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      d = (i == 0) ? 8'h00 : 8'(8'h30 + i);
      // Byte 0 goes straight to the shifter, so DEPTH more fit before full
      exp_err = (i > DEPTH) ? 1'b1 : 1'b0;
      apb_write(TX_A, 32'(d), err);
      if (i == 0) first_cyc = cyc;
      if (!exp_err) sb_push(d);
      checks++; if (err !== exp_err) $display("FAIL fill_slverr_%0d: got %b, required %b", i, err, exp_err); else passed++;
    end
    apb_read(ST_A, rd, err);
    exp_st = (32'(DEPTH) << 7) | 32'h5 | PAR_STATUS;
    checks++; if (rd !== exp_st) $display("FAIL fill_status: got 0x%08h, required 0x%08h", rd, exp_st); else passed++;
    // Land inside data bit 4 of byte 0x00
    while (cyc < first_cyc + 5500) @(posedge clk_in);
    #2;
    checks++; if (uart_tx !== 1'b0) $display("FAIL mid_frame_line: got %b, required 0", uart_tx); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) $display("FAIL async_reset_tx: got %b, required 1", uart_tx); else passed++;
    repeat (2) @(negedge clk_in);
    exp_q.delete();
    starts.delete();
    cur_div = 16'd68;
    reset = 1'b0;
    apb_read(ST_A, rd, err);
    checks++; if (rd !== (32'h2 | PAR_STATUS)) $display("FAIL post_reset_status: got 0x%08h, required 0x%08h", rd, 32'h2 | PAR_STATUS); else passed++;
    repeat (300) @(negedge clk_in);
    checks++; if (starts.size() != 0) $display("FAIL residual_frame: got %0d starts, required 0", starts.size()); else passed++;
    checks++; if (uart_tx !== 1'b1) $display("FAIL post_reset_idle: got %b, required 1", uart_tx); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_offset();
    test_baud_change();
`ifdef DIDACTIC_UART_TX_PARITY_EN
    test_parity();
`endif
    test_overflow_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
